// File: rtl/config_bank_pkg.sv
// Shared types and helpers for the configuration bank programmer.
package config_bank_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_DONE
   } cbp_state_t;

   // Index width for a counter that has n distinct values, never narrower than one bit.
   function automatic int cbp_clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/config_bank_wl_decoder.sv
// Row index to one-hot word-line decoder; combinational, registered by the parent.
module config_bank_wl_decoder
   import config_bank_pkg::*;
#(
   parameter int NUM_WL = 8,
   parameter int ROW_W  = cbp_clog2_min1(NUM_WL)
) (
   input  logic [ROW_W-1:0]  row,
   input  logic              en,
   output logic [NUM_WL-1:0] wl
);

   always_comb begin
      wl = '0;
      for (int i = 0; i < NUM_WL; i++) begin
         if (en && (row == ROW_W'(i))) begin
            wl[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/config_bank_programmer.sv
// Serial bitstream to config-latch array writer: clears the array, then loads and
// strobes one bit-line word per row.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | cfg_reset high for CLEAR_CYC cycles
// LOAD  | din_ready high, assembling one row from beats
// SETUP | row word copied to bl, wl still low
// PULSE | wl[row] high for PULSE_CYC cycles
// HOLD  | wl low, bl held, advance row
// DONE  | one-cycle done pulse
module config_bank_programmer
   import config_bank_pkg::*;
#(
   parameter int NUM_BL    = 8,
   parameter int NUM_WL    = 8,
   parameter int DIN_W     = 1,
   parameter int PULSE_CYC = 2,
   parameter int CLEAR_CYC = 2
) (
   input  logic              prog_clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [DIN_W-1:0]  din,
   output logic [NUM_BL-1:0] bl,
   output logic [NUM_WL-1:0] wl,
   output logic              cfg_reset,
   output logic              busy,
   output logic              done
);

   localparam int BEATS   = NUM_BL / DIN_W;
   localparam int ROW_W   = cbp_clog2_min1(NUM_WL);
   localparam int BEAT_W  = cbp_clog2_min1(BEATS);
   localparam int TMR_MAX = (PULSE_CYC > CLEAR_CYC) ? PULSE_CYC : CLEAR_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(NUM_WL - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);
   localparam logic [TMR_W-1:0]  TMR_CLEAR  = TMR_W'(CLEAR_CYC - 1);
   localparam logic [TMR_W-1:0]  TMR_PULSE  = TMR_W'(PULSE_CYC - 1);

   generate
      if ((NUM_BL % DIN_W) != 0) begin : g_bad_din_w
         $error("config_bank_programmer: NUM_BL must be a multiple of DIN_W");
      end
      if ((PULSE_CYC < 1) || (CLEAR_CYC < 1)) begin : g_bad_cyc
         $error("config_bank_programmer: PULSE_CYC and CLEAR_CYC must be at least 1");
      end
   endgenerate

   cbp_state_t        state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [NUM_BL-1:0] shift_q, shift_d;
   logic [NUM_BL-1:0] bl_q, bl_d;
   logic [NUM_WL-1:0] wl_q, wl_d;
   logic              din_ready_q, din_ready_d;
   logic              cfg_reset_q, cfg_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      beat_d  = beat_q;
      tmr_d   = tmr_q;
      shift_d = shift_q;
      bl_d    = bl_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CLEAR;
               tmr_d   = TMR_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (tmr_q == '0) begin
               state_d = ST_LOAD;
               row_d   = '0;
               beat_d  = '0;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         ST_LOAD: begin
            if (din_valid && din_ready_q) begin
               shift_d[int'(beat_q)*DIN_W +: DIN_W] = din;
               if (beat_q == BEAT_LAST) begin
                  // bl is loaded on SETUP entry so it is settled a full cycle before wl rises
                  state_d = ST_SETUP;
                  bl_d    = shift_d;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_PULSE;
            tmr_d   = TMR_PULSE;
         end
         ST_PULSE: begin
            if (tmr_q == '0) begin
               state_d = ST_HOLD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (row_q == ROW_LAST) begin
               state_d = ST_DONE;
               row_d   = '0;
            end else begin
               state_d = ST_LOAD;
               row_d   = row_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d      = (state_d != ST_IDLE);
      cfg_reset_d = (state_d == ST_CLEAR);
      din_ready_d = (state_d == ST_LOAD);
      done_d      = (state_d == ST_DONE);
   end

   config_bank_wl_decoder #(
      .NUM_WL (NUM_WL),
      .ROW_W  (ROW_W)
   ) u_wl_dec (
      .row (row_q),
      .en  (state_d == ST_PULSE),
      .wl  (wl_d)
   );

   always_ff @(posedge prog_clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         beat_q      <= '0;
         tmr_q       <= '0;
         shift_q     <= '0;
         bl_q        <= '0;
         wl_q        <= '0;
         din_ready_q <= 1'b0;
         cfg_reset_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         beat_q      <= beat_d;
         tmr_q       <= tmr_d;
         shift_q     <= shift_d;
         bl_q        <= bl_d;
         wl_q        <= wl_d;
         din_ready_q <= din_ready_d;
         cfg_reset_q <= cfg_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign din_ready = din_ready_q;
   assign bl        = bl_q;
   assign wl        = wl_q;
   assign cfg_reset = cfg_reset_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_config_bank_programmer.sv
// Bench for config_bank_programmer: 8x4 array with 4-bit beats plus a 3x1 array with 1-bit beats.
module tb_config_bank_programmer;

   localparam int NBL = 8;
   localparam int NWL = 4;
   localparam int DW  = 4;

   typedef struct {
      logic [DW-1:0] d;
      int            gap;
   } beat_t;

   typedef struct {
      int             row;
      logic [NBL-1:0] w;
   } exp_t;

   logic prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   logic           reset_n = 1'b0;
   logic           start = 1'b0;
   logic           din_valid = 1'b0;
   logic [DW-1:0]  din = '0;
   logic           din_ready;
   logic [NBL-1:0] bl;
   logic [NWL-1:0] wl;
   logic           cfg_reset, busy, done;

   logic           start1 = 1'b0;
   logic           din1_valid = 1'b0;
   logic [0:0]     din1 = '0;
   logic           din1_ready;
   logic [2:0]     bl1;
   logic [0:0]     wl1;
   logic           cfg_reset1, busy1, done1;

   int n_cmp = 0;
   int n_err = 0;

   beat_t beat_q[$];
   exp_t  exp_q[$];
   bit    abort  = 1'b0;
   bit    mon_en = 1'b0;

   logic [NBL-1:0] lat [NWL];

   config_bank_programmer #(
      .NUM_BL(NBL), .NUM_WL(NWL), .DIN_W(DW), .PULSE_CYC(2), .CLEAR_CYC(2)
   ) dut (
      .prog_clk(prog_clk), .reset_n(reset_n), .start(start),
      .din_valid(din_valid), .din_ready(din_ready), .din(din),
      .bl(bl), .wl(wl), .cfg_reset(cfg_reset), .busy(busy), .done(done)
   );

   config_bank_programmer #(
      .NUM_BL(3), .NUM_WL(1), .DIN_W(1), .PULSE_CYC(2), .CLEAR_CYC(2)
   ) dut1 (
      .prog_clk(prog_clk), .reset_n(reset_n), .start(start1),
      .din_valid(din1_valid), .din_ready(din1_ready), .din(din1),
      .bl(bl1), .wl(wl1), .cfg_reset(cfg_reset1), .busy(busy1), .done(done1)
   );

   // config_latch models for the main array
   always @(posedge prog_clk) begin
      for (int r = 0; r < NWL; r++) begin
         if (cfg_reset) lat[r] <= '0;
         else if (wl[r]) lat[r] <= bl;
      end
   end

   // bitstream feeder: drains beat_q over the valid/ready handshake
   initial begin : feeder
      beat_t b;
      forever begin
         @(posedge prog_clk); #1;
         if (beat_q.size() == 0 || abort) begin
            din_valid = 1'b0;
         end else begin
            b = beat_q.pop_front();
            if (b.gap > 0) begin
               din_valid = 1'b0;
               repeat (b.gap) begin @(posedge prog_clk); #1; end
            end
            din_valid = 1'b1;
            din       = b.d;
            for (int n = 0; n < 400; n++) begin
               @(negedge prog_clk);
               if (abort || din_ready) break;
               if (n == 399) begin
                  n_err++;
                  $display("FAIL feeder_timeout: din_ready stayed 0, required 1");
               end
            end
            if (abort) din_valid = 1'b0;
         end
      end
   end

   // invariants and row scoreboard
   logic [NWL-1:0] wl_prev = '0;
   logic [NBL-1:0] bl_prev = '0;
   int             wl_run = 0;
   always @(negedge prog_clk) begin
      exp_t e;
      if (mon_en) begin
         n_cmp++;
         if (!$onehot0(wl)) begin
            n_err++; $display("FAIL wl_onehot: wl=%b required at most one bit", wl);
         end
         n_cmp++;
         if ((wl != '0) && cfg_reset) begin
            n_err++; $display("FAIL wl_vs_cfg_reset: wl=%b cfg_reset=%b required not both", wl, cfg_reset);
         end
         n_cmp++;
         if (din_ready && (!busy || cfg_reset || (wl != '0) || done)) begin
            n_err++; $display("FAIL din_ready_outside_load: ready=%b busy=%b cfg_reset=%b wl=%b done=%b",
                              din_ready, busy, cfg_reset, wl, done);
         end
         if (wl != '0) begin
            n_cmp++;
            if (bl !== bl_prev) begin
               n_err++; $display("FAIL bl_stable: bl=%h required %h while wl high", bl, bl_prev);
            end
         end
         if ((wl != '0) && (wl_prev == '0)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL sb_empty: got wl=%b bl=%h required no pulse", wl, bl);
            end else begin
               e = exp_q.pop_front();
               if ((wl !== NWL'(1 << e.row)) || (bl !== e.w)) begin
                  n_err++; $display("FAIL sb_row: got wl=%b bl=%h required wl=%b bl=%h",
                                    wl, bl, NWL'(1 << e.row), e.w);
               end
            end
         end
         if (wl != '0) begin
            wl_run++;
         end else if (wl_prev != '0) begin
            if (!abort) begin
               n_cmp++;
               if (wl_run != 2) begin
                  n_err++; $display("FAIL wl_pulse_len: got %0d cycles required 2", wl_run);
               end
            end
            wl_run = 0;
         end
      end
      wl_prev = wl;
      bl_prev = bl;
   end

   task automatic push_rows(input int stall_row, input int stall_cyc);
      for (int r = 0; r < NWL; r++) begin
         beat_q.push_back('{d: DW'(5 + r), gap: 0});
         beat_q.push_back('{d: 4'hA, gap: (r == stall_row) ? stall_cyc : 0});
         exp_q.push_back('{row: r, w: {4'hA, DW'(5 + r)}});
      end
   endtask

   task automatic run_program(input int stall_row, input int stall_cyc, input int poke_row,
                              input bit poke_done, input int exp_cyc);
      int  nclr = 0;
      int  ndone = 0;
      int  dcyc = -1;
      bit  poked = 1'b0;
      bit  clr_chk = 1'b0;
      push_rows(stall_row, stall_cyc);
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
      n_cmp++;
      if (!(cfg_reset && busy)) begin
         n_err++; $display("FAIL start_response: cfg_reset=%b busy=%b required 1 1", cfg_reset, busy);
      end
      for (int k = 0; k < 120; k++) begin
         start = 1'b0;
         if (cfg_reset) nclr++;
         if (din_ready && !clr_chk) begin
            clr_chk = 1'b1;
            for (int r = 0; r < NWL; r++) begin
               n_cmp++;
               if (lat[r] !== '0) begin
                  n_err++; $display("FAIL latch_cleared: row %0d got %h required 00", r, lat[r]);
               end
            end
         end
         if (done) begin
            ndone++;
            if (dcyc < 0) dcyc = k;
         end
         if (poke_row >= 0 && !poked && wl == NWL'(1 << poke_row)) begin
            start = 1'b1;
            poked = 1'b1;
         end
         if (poke_done && dcyc == k) start = 1'b1;
         if (poke_done && dcyc >= 0 && (k == dcyc + 1 || k == dcyc + 2)) begin
            n_cmp++;
            if (busy !== 1'b0) begin
               n_err++; $display("FAIL start_at_done: busy=%b required 0", busy);
            end
         end
         if (dcyc >= 0 && k > dcyc + 3) break;
         @(posedge prog_clk); #1;
      end
      start = 1'b0;
      n_cmp++;
      if (dcyc != exp_cyc) begin
         n_err++; $display("FAIL done_cycle: got %0d required %0d", dcyc, exp_cyc);
      end
      n_cmp++;
      if (ndone != 1) begin
         n_err++; $display("FAIL done_count: got %0d required 1", ndone);
      end
      n_cmp++;
      if (nclr != 2) begin
         n_err++; $display("FAIL cfg_reset_len: got %0d required 2", nclr);
      end
      for (int r = 0; r < NWL; r++) begin
         n_cmp++;
         if (lat[r] !== {4'hA, DW'(5 + r)}) begin
            n_err++; $display("FAIL latch_data: row %0d got %h required %h", r, lat[r], {4'hA, DW'(5 + r)});
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL sb_leftover: got %0d rows unwritten required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge prog_clk);
      #1;
      n_cmp++;
      if ({wl, bl, cfg_reset, din_ready, busy, done} !== '0) begin
         n_err++; $display("FAIL reset_state: wl=%b bl=%h cfg_reset=%b ready=%b busy=%b done=%b required all 0",
                           wl, bl, cfg_reset, din_ready, busy, done);
      end
      n_cmp++;
      if ({wl1, bl1, cfg_reset1, din1_ready, busy1, done1} !== '0) begin
         n_err++; $display("FAIL reset_state_narrow: wl=%b bl=%b busy=%b required all 0", wl1, bl1, busy1);
      end
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(posedge prog_clk); #1;
   endtask

   task automatic test_full_program();
      run_program(-1, 0, -1, 1'b0, 26);
   endtask

   task automatic test_stall();
      run_program(1, 3, -1, 1'b0, 29);
   endtask

   task automatic test_start_ignored();
      run_program(-1, 0, 2, 1'b1, 26);
   endtask

   task automatic test_reset_mid_pulse();
      bit seen = 1'b0;
      push_rows(-1, 0);
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (wl == 4'b0010) begin seen = 1'b1; break; end
         @(posedge prog_clk); #1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++; $display("FAIL reset_wait_row1: wl=%b required 0010 within 60 cycles", wl);
      end
      reset_n = 1'b0;
      @(posedge prog_clk); #1;
      reset_n = 1'b1;
      abort   = 1'b1;
      beat_q.delete();
      exp_q.delete();
      n_cmp++;
      if ({wl, bl, busy, din_ready, cfg_reset, done} !== '0) begin
         n_err++; $display("FAIL reset_mid_pulse: wl=%b bl=%h busy=%b ready=%b required all 0",
                           wl, bl, busy, din_ready);
      end
      n_cmp++;
      if (lat[0] !== 8'hA5) begin
         n_err++; $display("FAIL reset_keeps_row0: got %h required a5", lat[0]);
      end
      repeat (3) @(posedge prog_clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || din_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_idle: busy=%b ready=%b required 0 0", busy, din_ready);
      end
      abort = 1'b0;
      @(posedge prog_clk); #1;
      run_program(-1, 0, -1, 1'b0, 26);
   endtask

   task automatic test_narrow();
      logic [2:0] nb = 3'b101;
      int  idx = 0;
      int  dcyc = -1;
      int  nwl = 0;
      int  nclr = 0;
      bit  acc;
      start1 = 1'b1;
      din1_valid = 1'b1;
      din1 = nb[0];
      @(posedge prog_clk); #1;
      start1 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (cfg_reset1) nclr++;
         if (wl1[0]) begin
            nwl++;
            n_cmp++;
            if (bl1 !== 3'b101) begin
               n_err++; $display("FAIL narrow_bl: got %b required 101", bl1);
            end
         end
         if (done1 && dcyc < 0) dcyc = k;
         if (dcyc >= 0) break;
         acc = din1_ready && din1_valid;
         @(posedge prog_clk); #1;
         if (acc) begin
            idx++;
            if (idx >= 3) din1_valid = 1'b0;
            else din1 = nb[idx];
         end
      end
      din1_valid = 1'b0;
      n_cmp++;
      if (dcyc != 9) begin
         n_err++; $display("FAIL narrow_done_cycle: got %0d required 9", dcyc);
      end
      n_cmp++;
      if (nwl != 2) begin
         n_err++; $display("FAIL narrow_wl_len: got %0d required 2", nwl);
      end
      n_cmp++;
      if (nclr != 2) begin
         n_err++; $display("FAIL narrow_clear_len: got %0d required 2", nclr);
      end
      n_cmp++;
      if (bl1 !== 3'b101) begin
         n_err++; $display("FAIL narrow_bl_after: got %b required 101", bl1);
      end
   endtask

   initial begin
      test_reset();
      test_full_program();
      test_stall();
      test_start_ignored();
      test_reset_mid_pulse();
      test_narrow();
      repeat (2) @(posedge prog_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/config_bank_programmer.md
# config_bank_programmer

Configuration writer for a memory-bank array of `config_latch` cells. It accepts a serial bitstream over a valid/ready stream, assembles one row of bit-line data at a time, and drives the `bl` bus and a one-hot `wl` pulse so each latch row captures its word. It first pulses `cfg_reset` to clear the whole array. It sits between the bitstream loader and the configuration-memory fabric, in the programming clock domain.

## Interface
Parameters:
- `NUM_BL`, 8: bit-lines per row (latch columns).
- `NUM_WL`, 8: word-lines (rows).
- `DIN_W`, 1: bitstream beat width; `NUM_BL % DIN_W == 0` is required (elaboration error otherwise).
- `PULSE_CYC`, 2: word-line high time in cycles, ≥1.
- `CLEAR_CYC`, 2: `cfg_reset` high time in cycles, ≥1.

Ports:
- `prog_clk` in 1: programming clock; one clock domain only.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a full-array program; sampled only in IDLE.
- `din_valid` in 1: bitstream beat valid.
- `din_ready` out 1: beat accepted on `din_valid && din_ready`.
- `din` in DIN_W: beat data; `din[0]` maps to the lowest pending bit-line.
- `bl` out NUM_BL: bit-line data to the latches.
- `wl` out NUM_WL: one-hot word-line enables.
- `cfg_reset` out 1: active-high array clear, driven to the latches' `reset`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last row has been written.

## Operation
- States: IDLE, CLEAR, LOAD, SETUP, PULSE, HOLD, DONE.
- IDLE: `start` moves to CLEAR.
- CLEAR: `cfg_reset` is high for exactly CLEAR_CYC cycles, then the FSM enters LOAD with row=0.
- LOAD: `din_ready` is high. Each accepted beat fills the row shift register LSB-first, so beat k lands in bits [k*DIN_W +: DIN_W]. After NUM_BL/DIN_W beats the FSM enters SETUP. `din_valid` low stalls the FSM in LOAD with no timeout.
- SETUP: the shift register is copied into the `bl` output register. `wl` stays all-zero for 1 cycle.
- PULSE: `wl[row]` is high for exactly PULSE_CYC cycles and `bl` is stable.
- HOLD: `wl` is zero and `bl` is held for 1 cycle. Then row increments. If row was NUM_WL-1 the FSM goes to DONE, otherwise to LOAD.
- DONE: `done` is high for 1 cycle, then the FSM returns to IDLE.
- `bl` keeps its value until the next SETUP, including across IDLE.
- Invariants: at most one `wl` bit is high. `wl` and `cfg_reset` are never high together. `bl` never changes while any `wl` bit is high. `din_ready` is low outside LOAD.
- `start` is ignored while `busy`.

## Timing
- All outputs are registered.
- Reset values: `wl`=0, `bl`=0, `cfg_reset`=0, `din_ready`=0, `busy`=0, `done`=0, state=IDLE, row=0.
- If `start` is sampled high at edge n, `cfg_reset` and `busy` are high from edge n+1.
- Per-row cost with `din_valid` held high is NUM_BL/DIN_W + PULSE_CYC + 2 cycles.
- Total cycles from the first CLEAR cycle to `done` is CLEAR_CYC + NUM_WL*(NUM_BL/DIN_W + PULSE_CYC + 2), with `done` in the next cycle.
- Reset mid-operation: all outputs take their reset values at the first edge where `reset_n` is sampled low. Rows already written remain in the latches, which are cleared only by the next CLEAR. A beat presented in the reset cycle is not accepted.
- `start` asserted in the same cycle as the DONE pulse is ignored. `start` is accepted from IDLE on the following cycle.
- Counter widths:
  - row counter: $clog2(NUM_WL), minimum 1.
  - beat counter: $clog2(NUM_BL/DIN_W), minimum 1.
  - pulse/clear counter: $clog2(max(PULSE_CYC, CLEAR_CYC)+1).
  - Each counter's terminal count is compared exactly; none wraps.

## Structure
- Package `config_bank_pkg` holds the state enum `cbp_state_t` and the helper function `cbp_clog2_min1`.
- One sub-module: `config_bank_wl_decoder`, a row index to one-hot `wl` decoder with enable, output registered in the parent.
- The FSM, counters and shift register live in the top module.

## Test plan
Parameters: NUM_BL=8, NUM_WL=4, DIN_W=4, PULSE_CYC=2, CLEAR_CYC=2, with `config_latch` models attached to the outputs.
- Full program, continuous valid, beats 0x5,0xA per row (row r adds r to the low nibble): `cfg_reset` high 2 cycles, `done` 26 cycles after `start`, latch rows read 0xA5,0xA6,0xA7,0xA8.
- `din_valid` low 3 cycles between the two beats of row 1: LOAD stalls, `wl` stays 0, `done` arrives 3 cycles later, data is unchanged.
- `start` pulsed during PULSE of row 2: ignored, with one `done` only.
- `reset_n` low for 1 cycle during PULSE of row 1: `wl`=0, `bl`=0, `busy`=0 next cycle. Row 0 latch keeps 0xA5. A restart clears it before rewriting.
- Every cycle check one-hot `wl`, no `bl` change while `wl`≠0, `din_ready` only in LOAD, and `wl` and `cfg_reset` never high together.
- DIN_W=1, NUM_BL=3, NUM_WL=1, bits 1,0,1: `bl`=3'b101, `wl[0]` high exactly 2 cycles, `done` at cycle 2+3+2+2=9.
